// File: rtl/lifo_stack_if.sv
// Request/response bundle between the recursive-evaluation controller and lifo_stack.
// Optional high-water-mark output appears only when LIFO_STACK_HWM_EN is defined.
interface lifo_stack_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic             push;
   logic             pop;
   logic             top;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] stack_out;
   logic             empty;
   logic             full;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             underflow;
`ifdef LIFO_STACK_HWM_EN
   logic [PTR_W:0]   hwm;
`endif

   modport master (
      output push, pop, top, din,
`ifdef LIFO_STACK_HWM_EN
      input  hwm,
`endif
      input  stack_out, empty, full, count, overflow, underflow
   );

   modport slave (
      input  push, pop, top, din,
`ifdef LIFO_STACK_HWM_EN
      output hwm,
`endif
      output stack_out, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/lifo_stack.sv
// Parameterised LIFO with zero-latency top read, replace-top on push+pop and sticky misuse flags.
// Define LIFO_STACK_HWM_EN to add the hwm (max occupancy since reset) output.
module lifo_stack #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
) (
   input logic        clk,
   input logic        rst,
   lifo_stack_if.slave bus
);
   localparam int             PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0] SP_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0] SP_MAX = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_sp;
   logic [WIDTH-1:0] r_last;
   logic             r_ovf;
   logic             r_unf;

   logic [PTR_W:0]   w_sp_d;
   logic [PTR_W-1:0] w_top_idx;
   logic [PTR_W-1:0] w_wr_idx;
   logic [WIDTH-1:0] w_top_data;
   logic             w_empty;
   logic             w_full;
   logic             w_push_new;
   logic             w_replace;
   logic             w_pop_only;
   logic             w_wr_en;

   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == SP_MAX);
   // Low bits only: at sp == DEPTH they are zero and the decrement wraps to DEPTH-1.
   assign w_top_idx  = r_sp[PTR_W-1:0] - PTR_W'(1);
   assign w_top_data = r_mem[w_top_idx];

   // Push onto an empty stack still happens when paired with a (rejected) pop.
   assign w_push_new = bus.push && !w_full && (!bus.pop || w_empty);
   assign w_replace  = bus.push && bus.pop && !w_empty;
   assign w_pop_only = bus.pop && !bus.push && !w_empty;
   assign w_wr_en    = w_push_new || w_replace;
   assign w_wr_idx   = w_replace ? w_top_idx : r_sp[PTR_W-1:0];

   always_comb begin
      w_sp_d = r_sp;
      if (w_push_new) begin
         w_sp_d = r_sp + SP_ONE;
      end else if (w_pop_only) begin
         w_sp_d = r_sp - SP_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp   <= '0;
         r_last <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         r_sp <= w_sp_d;
         if (w_replace || w_pop_only) begin
            r_last <= w_top_data;
         end
         if (bus.push && !bus.pop && w_full) begin
            r_ovf <= 1'b1;
         end
         if (bus.pop && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   // Storage is never cleared; reset only suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_en) begin
         r_mem[w_wr_idx] <= bus.din;
      end
   end

`ifdef LIFO_STACK_HWM_EN
   logic [PTR_W:0] r_hwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hwm <= '0;
      end else if (w_sp_d > r_hwm) begin
         r_hwm <= w_sp_d;
      end
   end

   assign bus.hwm = r_hwm;
`endif

   always_comb begin
      bus.stack_out = r_last;
      if (bus.top) begin
         bus.stack_out = w_empty ? '0 : w_top_data;
      end
   end

   assign bus.empty     = w_empty;
   assign bus.full      = w_full;
   assign bus.count     = r_sp;
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;
endmodule

// File: tb/tb_lifo_stack.sv
// Directed plus randomized bench for lifo_stack, checked against a queue-based stack model.
module tb_lifo_stack;
   localparam int WIDTH = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a queue whose back is the top of stack.
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_last;
   bit               m_ovf;
   bit               m_unf;
   int               m_hwm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] exp_out;
      if (bus.top) exp_out = (m_q.size() != 0) ? 32'(m_q[$]) : 32'd0;
      else         exp_out = 32'(m_last);
      chk("stack_out", 32'(bus.stack_out), exp_out);
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
      chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef LIFO_STACK_HWM_EN
      chk("hwm", 32'(bus.hwm), 32'(m_hwm));
`endif
   endtask

   task automatic model_step(input bit r, input bit p, input bit o, input logic [WIDTH-1:0] d);
      if (r) begin
         m_q.delete();
         m_last = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_hwm  = 0;
         return;
      end
      if (o && m_q.size() == 0) begin
         m_unf = 1'b1;
         if (p) m_q.push_back(d);
      end else if (p && o) begin
         m_last   = m_q[$];
         m_q[$]   = d;
      end else if (o) begin
         m_last = m_q.pop_back();
      end else if (p) begin
         if (m_q.size() == DEPTH) m_ovf = 1'b1;
         else m_q.push_back(d);
      end
      if (m_q.size() > m_hwm) m_hwm = m_q.size();
   endtask

   // Inputs are applied 1 time unit after a rising edge; outputs checked before the next edge.
   task automatic cycle(input bit r, input bit p, input bit o, input bit t,
                        input logic [WIDTH-1:0] d);
      rst = r; bus.push = p; bus.pop = o; bus.top = t; bus.din = d;
      #2;
      check_model();
      model_step(r, p, o, d);
      @(posedge clk);
      #1;
      rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
   endtask

   initial begin
      bit r, p, o, t;
      int bias;
      rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.top = 1'b1; bus.din = '0;
      m_q.delete(); m_last = '0; m_ovf = 1'b0; m_unf = 1'b0; m_hwm = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
      bus.top = 1'b0; #1;
      chk("rst_last", 32'(bus.stack_out), 32'd0);
      bus.top = 1'b1; #1;

      // Push 3, 5; pop shows 5 during the pop cycle, then 3
      cycle(0, 1, 0, 1, 4'h3);
      cycle(0, 1, 0, 1, 4'h5);
      chk("tp1_count", 32'(bus.count), 32'd2);
      chk("tp1_top", 32'(bus.stack_out), 32'h5);
      bus.pop = 1'b1; #1;
      chk("tp1_pop_out", 32'(bus.stack_out), 32'h5);
      bus.pop = 1'b0;
      cycle(0, 0, 1, 1, '0);
      chk("tp1_after_pop", 32'(bus.stack_out), 32'h3);
      bus.top = 1'b0; #1;
      chk("tp1_last", 32'(bus.stack_out), 32'h5);
      bus.top = 1'b1; #1;

      // Fill to full, then overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 1, WIDTH'(i));
      chk("tp2_full", 32'(bus.full), 32'd1);
      chk("tp2_count", 32'(bus.count), 32'd16);
      cycle(0, 1, 0, 1, 4'hA);
      chk("tp2_ovf", 32'(bus.overflow), 32'd1);
      chk("tp2_count2", 32'(bus.count), 32'd16);
      chk("tp2_top", 32'(bus.stack_out), 32'hF);

      // Underflow is sticky
      do_reset();
      cycle(0, 0, 1, 1, '0);
      chk("tp3_unf", 32'(bus.underflow), 32'd1);
      chk("tp3_count", 32'(bus.count), 32'd0);
      chk("tp3_out", 32'(bus.stack_out), 32'd0);
      cycle(0, 1, 0, 1, 4'h1);
      cycle(0, 0, 1, 1, '0);
      chk("tp3_sticky", 32'(bus.underflow), 32'd1);

      // Replace-top, also at full
      do_reset();
      cycle(0, 1, 0, 1, 4'h2);
      cycle(0, 1, 0, 1, 4'h7);
      cycle(0, 1, 1, 1, 4'h9);
      chk("tp4_count", 32'(bus.count), 32'd2);
      chk("tp4_top", 32'(bus.stack_out), 32'h9);
      bus.top = 1'b0; #1;
      chk("tp4_last", 32'(bus.stack_out), 32'h7);
      bus.top = 1'b1; #1;
      for (int i = 0; i < DEPTH - 2; i++) cycle(0, 1, 0, 1, WIDTH'(i));
      cycle(0, 1, 1, 1, 4'hC);
      chk("tp4_full_ovf", 32'(bus.overflow), 32'd0);
      chk("tp4_full_top", 32'(bus.stack_out), 32'hC);
      chk("tp4_full_cnt", 32'(bus.count), 32'd16);

      // Controller pattern
      do_reset();
      cycle(0, 1, 0, 1, 4'h4);
      cycle(0, 1, 0, 1, 4'h2);
      bus.pop = 1'b1; #1;
      chk("tp5_load1", 32'(bus.stack_out), 32'h2);
      bus.pop = 1'b0;
      cycle(0, 0, 1, 1, '0);
      bus.pop = 1'b1; #1;
      chk("tp5_load2", 32'(bus.stack_out), 32'h4);
      bus.pop = 1'b0;
      cycle(0, 0, 1, 1, '0);
      chk("tp5_empty", 32'(bus.empty), 32'd1);
`ifdef LIFO_STACK_HWM_EN
      chk("tp5_hwm", 32'(bus.hwm), 32'd2);
`endif

      // Mid-sequence reset with pop asserted
      do_reset();
      cycle(0, 0, 1, 1, '0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, WIDTH'(i + 8));
      cycle(1, 0, 1, 1, '0);
      chk("tp6_count", 32'(bus.count), 32'd0);
      chk("tp6_empty", 32'(bus.empty), 32'd1);
      chk("tp6_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
      cycle(0, 1, 0, 1, 4'h6);
      chk("tp6_mem0", 32'(dut.r_mem[0]), 32'h6);
      chk("tp6_top", 32'(bus.stack_out), 32'h6);

      // Randomized phases alternating push-heavy and pop-heavy traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         bias = ((i / 60) % 2 == 0) ? 75 : 30;
         r = ($urandom_range(0, 99) == 0);
         p = ($urandom_range(0, 99) < bias);
         o = ($urandom_range(0, 99) < (100 - bias));
         t = ($urandom_range(0, 3) != 0);
         cycle(r, p, o, t, WIDTH'($urandom));
      end
      cycle(0, 0, 0, 1, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
